lcd_row_writer: RTL and testbench
=================================

Name: lcd_row_writer

Overview:
- Consumes the two 128-bit ASCII row buffers produced by the display FSM (16 chars each, leftmost char in bits [127:120]).
- Drives a 16x2 HD44780-compatible character LCD over its 8-bit parallel write-only bus: runs the power-up init sequence once, then refreshes both rows continuously.
- Sits between the display FSM and the LCD pins at the top level.

Parameters:
- POWERUP_CYCLES, 500000, idle cycles after reset before the first command (en held low).
- SETUP_CYCLES, 2, cycles rs/data are stable with en=0 before the en pulse.
- EN_CYCLES, 5, en high width in cycles.
- WAIT_CYCLES, 500, cycles en=0 after each byte before the next byte starts (data/rs held).
- CLEAR_CYCLES, 20000, replaces WAIT_CYCLES after the clear-display command only.
- CNT_W, 20, delay counter width; must hold the largest cycle parameter.

Ports:
- clk  in  1  system clock.
- nRst  in  1  asynchronous active-low reset.
- row1  in  128  line-1 ASCII, char 0 = [127:120] ... char 15 = [7:0].
- row2  in  128  line-2 ASCII, same packing.
- lcd_en  out  1  LCD enable strobe.
- lcd_rs  out  1  0 = command, 1 = character data.
- lcd_rw  out  1  tied 0 (write only).
- lcd_data  out  8  LCD data bus.
- init_done  out  1  high once the init sequence completes; stays high until reset.
- frame_done  out  1  one-cycle pulse when the last char of row 2 finishes its WAIT phase.

Behaviour:
- Reset (async, nRst=0): lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, frame_done=0, FSM=POWERUP, counter=0, snapshots cleared to 8'h20 (space). Reset mid-transfer aborts immediately and en drops in the same instant.
- Byte transfer primitive: SETUP (SETUP_CYCLES, en=0) -> PULSE (EN_CYCLES, en=1) -> WAIT (WAIT_CYCLES, or CLEAR_CYCLES for 0x01, en=0). Cost is S+E+W cycles per byte.
- lcd_rs and lcd_data change only on the first SETUP cycle of a byte and are held through that byte's WAIT.
- The next byte's SETUP starts on the cycle after WAIT ends. There are no idle gaps except POWERUP.
- FSM states: POWERUP -> INIT (4 bytes) -> LINE1_ADDR -> LINE1_CHARS -> LINE2_ADDR -> LINE2_CHARS -> LINE1_ADDR (loop forever).
- POWERUP: count POWERUP_CYCLES cycles with outputs at reset values, then go to INIT.
- INIT sequence (rs=0): 0x38 (8-bit, 2-line), 0x0C (display on, cursor off), 0x06 (increment, no shift), 0x01 (clear; uses CLEAR_CYCLES).
  - init_done rises on the cycle after the 0x01 WAIT ends, concurrent with the first LINE1_ADDR SETUP cycle.
- Frame sequence:
  - cmd 0x80 (rs=0), then 16 chars of row1 (rs=1), char index 0..15.
  - cmd 0xC0 (rs=0), then 16 chars of row2 (rs=1).
  - 34 bytes per frame.
- Snapshot: row1 and row2 are both captured into internal registers on the first SETUP cycle of every LINE1_ADDR. Input changes mid-frame do not affect the frame in progress; no tearing between rows.
- Char index is a 4-bit counter: wraps 15 -> 0 on the row transition and is reset at each ADDR command.
- frame_done is high for exactly the one cycle in which the next LINE1_ADDR SETUP begins. It never pulses during init.
- Characters are sent verbatim with no filtering; 0x00 is a legal byte.
- lcd_rw is constant 0 in all states.

Test Plan:
- Overrides for all tests: POWERUP=10, SETUP=1, EN=2, WAIT=3, CLEAR=8 (6 cycles per byte, 11 for clear).
- Reset release -> en=0 for cycles 0-10; first en rise at cycle 11 with data=0x38, rs=0; en high exactly 2 cycles.
- Init check: capture the en-rising bytes in order -> 0x38, 0x0C, 0x06, 0x01. The gap from 0x01 en-fall to the next SETUP start is 8 cycles. init_done rises with data=0x80.
- row1 = "HELLO" padded with 0x20, row2 = ten 0x5F then six 0x20 -> 34 captured bytes per frame: 0x80, 'H','E','L','L','O', 11×0x20, 0xC0, 10×0x5F, 6×0x20. rs=1 exactly on the char bytes. frame_done pulses every 204 cycles.
- Change row1[127:120] from 'H' to 'Z' during char 3 of a frame -> the current frame still shows 'H'; the next frame's first char is 'Z'.
- Assert nRst during a PULSE of a LINE2 char -> en=0 and data=0x00 asynchronously; after release, full POWERUP+INIT repeats and init_done=0 until the clear completes.
- Check on every cycle that lcd_rs and lcd_data are stable whenever en=1 and in the SETUP cycle before it, and that lcd_rw stays 0.

Source files
------------

// File: rtl/lcd_row_writer.sv
// lcd_row_writer: drives a 16x2 HD44780-style LCD over an 8-bit write-only bus.
// Runs the power-up init sequence once, then refreshes both rows continuously
// from a per-frame snapshot of the two ASCII row buffers.
module lcd_row_writer #(
    parameter int unsigned POWERUP_CYCLES = 500000,
    parameter int unsigned SETUP_CYCLES   = 2,
    parameter int unsigned EN_CYCLES      = 5,
    parameter int unsigned WAIT_CYCLES    = 500,
    parameter int unsigned CLEAR_CYCLES   = 20000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic         clk,
    input  logic         nRst,
    input  logic [127:0] row1,
    input  logic [127:0] row2,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);

    localparam int unsigned ROW_W  = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [CNT_W-1:0] L_PWR_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_EN_LAST    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_WAIT_LAST  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_CLR_LAST   = CNT_W'(CLEAR_CYCLES - 1);

    localparam logic [ROW_W-1:0]  L_BLANK_ROW = {16{8'h20}};
    localparam logic [BYTE_W-1:0] L_CMD_CLEAR = 8'h01;
    localparam logic [BYTE_W-1:0] L_CMD_LINE1 = 8'h80;
    localparam logic [BYTE_W-1:0] L_CMD_LINE2 = 8'hC0;
    localparam logic [IDX_W-1:0]  L_IDX_LAST  = 4'd15;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_INIT,
        S_L1_ADDR,
        S_L1_CHARS,
        S_L2_ADDR,
        S_L2_CHARS
    } state_t;

    typedef enum logic [1:0] {
        P_SETUP,
        P_PULSE,
        P_WAIT
    } phase_t;

    state_t             r_state, w_state_nxt;
    phase_t             r_phase, w_phase_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_en, w_en_nxt;
    logic               r_rs, w_rs_nxt;
    logic [BYTE_W-1:0]  r_data, w_data_nxt;
    logic               r_init_done, w_init_done_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic [ROW_W-1:0]   r_snap1, w_snap1_nxt;
    logic [ROW_W-1:0]   r_snap2, w_snap2_nxt;

    logic               w_load;
    logic               w_new_rs;
    logic [BYTE_W-1:0]  w_new_data;
    logic [CNT_W-1:0]   w_wait_last;
    logic [IDX_W-1:0]   w_idx_inc;

    // Init command bytes in issue order.
    function automatic logic [BYTE_W-1:0] init_cmd(input logic [1:0] idx);
        logic [BYTE_W-1:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            default: cmd = L_CMD_CLEAR;
        endcase
        return cmd;
    endfunction

    // Character idx of a row; char 0 sits in the top byte.
    function automatic logic [BYTE_W-1:0] pick_char(input logic [ROW_W-1:0] row,
                                                    input logic [IDX_W-1:0] idx);
        logic [6:0] pos;
        pos = {4'(L_IDX_LAST - idx), 3'b000};
        return row[pos +: 8];
    endfunction

    // Only the clear command gets the long settle time.
    assign w_wait_last = (!r_rs && (r_data == L_CMD_CLEAR)) ? L_CLR_LAST : L_WAIT_LAST;
    assign w_idx_inc   = r_idx + IDX_W'(1);

    // State, phase counters, snapshots and registered pin values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state      <= S_POWERUP;
            r_phase      <= P_SETUP;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_en         <= 1'b0;
            r_rs         <= 1'b0;
            r_data       <= '0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_snap1      <= L_BLANK_ROW;
            r_snap2      <= L_BLANK_ROW;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_en         <= w_en_nxt;
            r_rs         <= w_rs_nxt;
            r_data       <= w_data_nxt;
            r_init_done  <= w_init_done_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_snap1      <= w_snap1_nxt;
            r_snap2      <= w_snap2_nxt;
        end
    end

    // Next-state: byte phase sequencing plus which byte follows when a WAIT ends.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_cnt_nxt        = r_cnt;
        w_idx_nxt        = r_idx;
        w_en_nxt         = r_en;
        w_rs_nxt         = r_rs;
        w_data_nxt       = r_data;
        w_init_done_nxt  = r_init_done;
        w_frame_done_nxt = 1'b0;
        w_snap1_nxt      = r_snap1;
        w_snap2_nxt      = r_snap2;
        w_load           = 1'b0;
        w_new_rs         = 1'b0;
        w_new_data       = '0;

        if (r_state == S_POWERUP) begin
            if (r_cnt == L_PWR_LAST) begin
                w_state_nxt = S_INIT;
                w_idx_nxt   = '0;
                w_load      = 1'b1;
                w_new_data  = init_cmd(2'd0);
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end else begin
            case (r_phase)
                P_SETUP: begin
                    if (r_cnt == L_SETUP_LAST) begin
                        w_phase_nxt = P_PULSE;
                        w_cnt_nxt   = '0;
                        w_en_nxt    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                P_PULSE: begin
                    if (r_cnt == L_EN_LAST) begin
                        w_phase_nxt = P_WAIT;
                        w_cnt_nxt   = '0;
                        w_en_nxt    = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                P_WAIT: begin
                    if (r_cnt == w_wait_last) begin
                        w_load = 1'b1;
                        case (r_state)
                            S_INIT: begin
                                if (r_idx == IDX_W'(3)) begin
                                    w_state_nxt     = S_L1_ADDR;
                                    w_idx_nxt       = '0;
                                    w_new_data      = L_CMD_LINE1;
                                    w_init_done_nxt = 1'b1;
                                    w_snap1_nxt     = row1;
                                    w_snap2_nxt     = row2;
                                end else begin
                                    w_idx_nxt  = w_idx_inc;
                                    w_new_data = init_cmd(w_idx_inc[1:0]);
                                end
                            end
                            S_L1_ADDR: begin
                                w_state_nxt = S_L1_CHARS;
                                w_idx_nxt   = '0;
                                w_new_rs    = 1'b1;
                                w_new_data  = pick_char(r_snap1, '0);
                            end
                            S_L1_CHARS: begin
                                w_idx_nxt = w_idx_inc;
                                if (r_idx == L_IDX_LAST) begin
                                    w_state_nxt = S_L2_ADDR;
                                    w_new_data  = L_CMD_LINE2;
                                end else begin
                                    w_new_rs   = 1'b1;
                                    w_new_data = pick_char(r_snap1, w_idx_inc);
                                end
                            end
                            S_L2_ADDR: begin
                                w_state_nxt = S_L2_CHARS;
                                w_idx_nxt   = '0;
                                w_new_rs    = 1'b1;
                                w_new_data  = pick_char(r_snap2, '0);
                            end
                            S_L2_CHARS: begin
                                w_idx_nxt = w_idx_inc;
                                if (r_idx == L_IDX_LAST) begin
                                    w_state_nxt      = S_L1_ADDR;
                                    w_new_data       = L_CMD_LINE1;
                                    w_frame_done_nxt = 1'b1;
                                    w_snap1_nxt      = row1;
                                    w_snap2_nxt      = row2;
                                end else begin
                                    w_new_rs   = 1'b1;
                                    w_new_data = pick_char(r_snap2, w_idx_inc);
                                end
                            end
                            default: begin
                                w_load = 1'b0;
                            end
                        endcase
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_phase_nxt = P_SETUP;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        if (w_load) begin
            w_phase_nxt = P_SETUP;
            w_cnt_nxt   = '0;
            w_en_nxt    = 1'b0;
            w_rs_nxt    = w_new_rs;
            w_data_nxt  = w_new_data;
        end
    end

    assign lcd_en     = r_en;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = r_data;
    assign init_done  = r_init_done;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_row_writer.sv
// Bench for lcd_row_writer: a byte-schedule reference model predicts every
// pin on every cycle; rows are fixed patterns first, then randomized.
module tb_lcd_row_writer;

    localparam int P_PWR   = 10;
    localparam int P_S     = 1;
    localparam int P_E     = 2;
    localparam int P_W     = 3;
    localparam int P_C     = 8;
    localparam int P_FRAME = 204;

    logic         clk;
    logic         nRst;
    logic [127:0] row1;
    logic [127:0] row2;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         frame_done;

    lcd_row_writer #(
        .POWERUP_CYCLES(P_PWR),
        .SETUP_CYCLES  (P_S),
        .EN_CYCLES     (P_E),
        .WAIT_CYCLES   (P_W),
        .CLEAR_CYCLES  (P_C),
        .CNT_W         (20)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .row1      (row1),
        .row2      (row2),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_err;
    int t;

    // Reference model: the current byte of the schedule and when it began.
    int           m_pos;
    int           m_f;
    int           m_start;
    int           m_len;
    logic         m_rs;
    logic [7:0]   m_data;
    logic         m_init_done;
    logic         m_fd;
    logic [127:0] m_snap1;
    logic [127:0] m_snap2;
    logic [7:0]   init_cmds [4];

    logic         prev_en;
    logic         prev_rs;
    logic [7:0]   prev_data;
    logic         prev_init;
    int           n_rise;
    int           last_fd;
    logic         z_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        logic [7:0]   c;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            c = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) c = 8'h00;
            r = {r[119:0], c};
        end
        return r;
    endfunction

    // Byte m_pos of the endless schedule: 4 init bytes, then 34-byte frames.
    task automatic model_start_byte();
        logic [127:0] tmp;
        m_start = t;
        if (m_pos < 4) begin
            m_f    = -1;
            m_rs   = 1'b0;
            m_data = init_cmds[m_pos];
        end else begin
            m_f = (m_pos - 4) % 34;
            if (m_f == 0) begin
                m_snap1 = row1;
                m_snap2 = row2;
                m_rs    = 1'b0;
                m_data  = 8'h80;
                if (m_init_done) m_fd = 1'b1;
                m_init_done = 1'b1;
            end else if (m_f <= 16) begin
                m_rs   = 1'b1;
                tmp    = m_snap1 >> (8 * (16 - m_f));
                m_data = tmp[7:0];
            end else if (m_f == 17) begin
                m_rs   = 1'b0;
                m_data = 8'hC0;
            end else begin
                m_rs   = 1'b1;
                tmp    = m_snap2 >> (8 * (33 - m_f));
                m_data = tmp[7:0];
            end
        end
        m_len = (!m_rs && m_data == 8'h01) ? (P_S + P_E + P_C) : (P_S + P_E + P_W);
    endtask

    task automatic step_and_check();
        logic       e_en;
        logic       e_rs;
        logic [7:0] e_data;
        m_fd = 1'b0;
        if (t == P_PWR) begin
            m_pos = 0;
            model_start_byte();
        end else if (t > P_PWR && t == m_start + m_len) begin
            m_pos++;
            model_start_byte();
        end
        if (t < P_PWR) begin
            e_en = 1'b0; e_rs = 1'b0; e_data = 8'h00;
        end else begin
            e_en   = (t - m_start >= P_S) && (t - m_start < P_S + P_E);
            e_rs   = m_rs;
            e_data = m_data;
        end
        check("en",         32'(lcd_en),     32'(e_en));
        check("rs",         32'(lcd_rs),     32'(e_rs));
        check("data",       32'(lcd_data),   32'(e_data));
        check("rw",         32'(lcd_rw),     32'(0));
        check("init_done",  32'(init_done),  32'(m_init_done));
        check("frame_done", 32'(frame_done), 32'(m_fd));

        if (lcd_en) begin
            check("rs_stable",   32'(lcd_rs),   32'(prev_rs));
            check("data_stable", 32'(lcd_data), 32'(prev_data));
        end
        if (lcd_en && !prev_en) begin
            if (n_rise == 0) check("first_en_rise_cycle", 32'(t), 32'(11));
            if (n_rise < 4)  check("init_byte", 32'(lcd_data), 32'(init_cmds[n_rise]));
            if (z_pending && m_f == 1) begin
                check("z_next_frame", 32'(lcd_data), 32'h5A);
                z_pending = 1'b0;
            end
            n_rise++;
        end
        if (init_done && !prev_init) check("init_done_data", 32'(lcd_data), 32'h80);
        if (frame_done) begin
            if (last_fd >= 0) check("frame_period", 32'(t - last_fd), 32'(P_FRAME));
            last_fd = t;
        end
        prev_en   = lcd_en;
        prev_rs   = lcd_rs;
        prev_data = lcd_data;
        prev_init = init_done;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            t++;
            @(negedge clk);
            step_and_check();
        end
    endtask

    // Release reset on a falling edge and restart the model at cycle 0.
    task automatic do_release();
        @(negedge clk);
        nRst        = 1'b1;
        t           = 0;
        m_pos       = 0;
        m_f         = -1;
        m_start     = 0;
        m_len       = 0;
        m_rs        = 1'b0;
        m_data      = 8'h00;
        m_init_done = 1'b0;
        prev_en     = 1'b0;
        prev_rs     = 1'b0;
        prev_data   = 8'h00;
        prev_init   = 1'b0;
        n_rise      = 0;
        last_fd     = -1;
        z_pending   = 1'b0;
        step_and_check();
    endtask

    initial begin
        int k;
        clk       = 1'b0;
        nRst      = 1'b0;
        n_checks  = 0;
        n_err     = 0;
        t         = 0;
        init_cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        row1      = {"HELLO", {11{8'h20}}};
        row2      = {{10{8'h5F}}, {6{8'h20}}};

        #12;
        check("rst_en",         32'(lcd_en),     32'(0));
        check("rst_data",       32'(lcd_data),   32'(0));
        check("rst_rs",         32'(lcd_rs),     32'(0));
        check("rst_init_done",  32'(init_done),  32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        do_release();

        // Init plus two fixed-pattern frames.
        run_cycles(P_PWR + 29 + 2 * P_FRAME);

        // Change char 0 of row1 while char 3 is being set up.
        k = 0;
        while (!(m_f == 4 && t == m_start) && k < 400) begin
            run_cycles(1);
            k++;
        end
        check("find_char3", 32'(k < 400), 32'(1));
        row1[127:120] = 8'h5A;
        z_pending     = 1'b1;
        run_cycles(2 * P_FRAME);
        check("z_seen", 32'(z_pending), 32'(0));

        // Random rows changing at random points mid-frame.
        repeat (10) begin
            run_cycles($urandom_range(20, 150));
            row1 = rand_row();
            row2 = rand_row();
        end
        run_cycles(P_FRAME);

        // Reset in the first PULSE cycle of a line-2 character.
        k = 0;
        while (!(m_f >= 18 && t == m_start + P_S) && k < 400) begin
            run_cycles(1);
            k++;
        end
        check("find_l2_pulse", 32'(k < 400), 32'(1));
        check("pre_reset_en", 32'(lcd_en), 32'(1));
        #2;
        nRst = 1'b0;
        #1;
        check("async_rst_en",        32'(lcd_en),    32'(0));
        check("async_rst_data",      32'(lcd_data),  32'(0));
        check("async_rst_rs",        32'(lcd_rs),    32'(0));
        check("async_rst_init_done", 32'(init_done), 32'(0));
        repeat (2) @(posedge clk);
        do_release();
        run_cycles(P_PWR + 29 + P_FRAME);
        repeat (4) begin
            row1 = rand_row();
            row2 = rand_row();
            run_cycles($urandom_range(50, 250));
        end
        run_cycles(P_FRAME);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
